bsg_sdr_link_reset_sequencer: RTL and testbench



---
 rtl/bsg_sdr_link_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_bsg_sdr_link_reset_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_sdr_link_reset_sequencer.sv
// SDR link bring-up sequencer: walks token/link/core resets and the node enable
// through fixed-length phases, with early stop, abort and synchronous reset.
module bsg_sdr_link_reset_sequencer #(
    parameter int unsigned step_cycles_p  = 100,
    parameter int unsigned run_cycles_p   = 5000,
    parameter int unsigned drain_cycles_p = 500
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       abort_i,
    output logic       async_token_reset_o,
    output logic       async_uplink_reset_o,
    output logic       async_downlink_reset_o,
    output logic       async_downstream_reset_o,
    output logic       core_reset_o,
    output logic       en_o,
    output logic       done_o,
    output logic [3:0] state_o
);

    localparam int unsigned max_a_lp      = (step_cycles_p > run_cycles_p) ? step_cycles_p
                                                                           : run_cycles_p;
    localparam int unsigned max_cycles_lp = (max_a_lp > drain_cycles_p) ? max_a_lp
                                                                        : drain_cycles_p;
    localparam int unsigned cnt_width_lp  = (max_cycles_lp + 1 <= 2) ? 1
                                                                     : $clog2(max_cycles_lp + 1);

    localparam logic [cnt_width_lp-1:0] step_ld_lp  = cnt_width_lp'(step_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] drain_ld_lp = cnt_width_lp'(drain_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] run_ld_lp   =
        (run_cycles_p == 0) ? '0 : cnt_width_lp'(run_cycles_p - 1);

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StTokHi      = 4'd1,
        StTokLo      = 4'd2,
        StUplink     = 4'd3,
        StDownlink   = 4'd4,
        StDownstream = 4'd5,
        StCore       = 4'd6,
        StRun        = 4'd7,
        StDrain      = 4'd8,
        StDone       = 4'd9
    } state_t;

    state_t                  state_q, state_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                    cnt_zero;

    logic tok_d, uplink_d, downlink_d, downstream_d, core_d, en_d, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_zero = (cnt_q == '0);
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d = StTokHi;
                        cnt_d   = step_ld_lp;
                    end
                end
                StTokHi, StTokLo, StUplink, StDownlink, StDownstream, StCore: begin
                    if (cnt_zero) begin
                        // Encodings are consecutive, so each bring-up phase advances by one.
                        state_d = state_t'(state_q + 4'd1);
                        cnt_d   = (state_q == StCore) ? run_ld_lp : step_ld_lp;
                    end else begin
                        cnt_d = cnt_q - cnt_width_lp'(1);
                    end
                end
                StRun: begin
                    if (stop_i || (run_cycles_p != 0 && cnt_zero)) begin
                        state_d = StDrain;
                        cnt_d   = drain_ld_lp;
                    end else if (run_cycles_p != 0) begin
                        cnt_d = cnt_q - cnt_width_lp'(1);
                    end
                end
                StDrain: begin
                    if (cnt_zero) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - cnt_width_lp'(1);
                    end
                end
                StDone: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered so they come straight from flops.
    always_comb begin
        tok_d        = (state_d == StTokHi);
        uplink_d     = (state_d < StUplink);
        downlink_d   = (state_d < StDownlink);
        downstream_d = (state_d < StDownstream);
        core_d       = (state_d < StCore);
        en_d         = (state_d == StRun);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q                  <= StIdle;
            cnt_q                    <= '0;
            async_token_reset_o      <= 1'b0;
            async_uplink_reset_o     <= 1'b1;
            async_downlink_reset_o   <= 1'b1;
            async_downstream_reset_o <= 1'b1;
            core_reset_o             <= 1'b1;
            en_o                     <= 1'b0;
            done_o                   <= 1'b0;
        end else begin
            state_q                  <= state_d;
            cnt_q                    <= cnt_d;
            async_token_reset_o      <= tok_d;
            async_uplink_reset_o     <= uplink_d;
            async_downlink_reset_o   <= downlink_d;
            async_downstream_reset_o <= downstream_d;
            core_reset_o             <= core_d;
            en_o                     <= en_d;
            done_o                   <= done_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_bsg_sdr_link_reset_sequencer.sv
// Bench for the bring-up sequencer: two instances (timed run and run-until-stop) checked
// every cycle against a timeline model of elapsed cycles since start.
module tb_bsg_sdr_link_reset_sequencer;

    localparam int S = 4;
    localparam int D = 3;
    localparam int RUNS [2] = '{10, 0};
    localparam int FOREVER = 1000000000;

    logic clk = 1'b0;
    logic reset, start, stop, abort;

    logic       tok   [2];
    logic       up    [2];
    logic       dn    [2];
    logic       ds    [2];
    logic       core  [2];
    logic       en    [2];
    logic       done  [2];
    logic [3:0] st    [2];

    int checks   = 0;
    int failures = 0;

    bit m_active  [2];
    int m_t       [2];
    int m_run_end [2];

    always #5 clk = ~clk;

    bsg_sdr_link_reset_sequencer #(
        .step_cycles_p(S), .run_cycles_p(10), .drain_cycles_p(D)
    ) dut0 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop), .abort_i(abort),
        .async_token_reset_o(tok[0]), .async_uplink_reset_o(up[0]),
        .async_downlink_reset_o(dn[0]), .async_downstream_reset_o(ds[0]),
        .core_reset_o(core[0]), .en_o(en[0]), .done_o(done[0]), .state_o(st[0])
    );

    bsg_sdr_link_reset_sequencer #(
        .step_cycles_p(S), .run_cycles_p(0), .drain_cycles_p(D)
    ) dut1 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop), .abort_i(abort),
        .async_token_reset_o(tok[1]), .async_uplink_reset_o(up[1]),
        .async_downlink_reset_o(dn[1]), .async_downstream_reset_o(ds[1]),
        .core_reset_o(core[1]), .en_o(en[1]), .done_o(done[1]), .state_o(st[1])
    );

    // Phase from elapsed cycles: five step phases, core, then run/drain/done.
    function automatic int phase(int i);
        int t = m_t[i];
        if (!m_active[i]) return 0;
        if (t < 6 * S) return t / S + 1;
        if (t < m_run_end[i]) return 7;
        if (t < m_run_end[i] + D) return 8;
        return 9;
    endfunction

    function automatic logic [10:0] exp_vec(int i);
        int p = phase(i);
        int t = m_t[i];
        if (!m_active[i]) return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        return {p == 1, t < 2 * S, t < 3 * S, t < 4 * S, t < 5 * S, p == 7, p == 9, 4'(p)};
    endfunction

    function automatic logic [10:0] dut_vec(int i);
        return {tok[i], up[i], dn[i], ds[i], core[i], en[i], done[i], st[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit st_i, input bit sp_i, input bit ab_i, input bit rs_i);
        for (int i = 0; i < 2; i++) begin
            if (rs_i || ab_i) begin
                m_active[i] = 1'b0;
            end else if (!m_active[i]) begin
                if (st_i) begin
                    m_active[i]  = 1'b1;
                    m_t[i]       = 0;
                    m_run_end[i] = (RUNS[i] == 0) ? FOREVER : 6 * S + RUNS[i];
                end
            end else begin
                if (sp_i && phase(i) == 7) m_run_end[i] = m_t[i] + 1;
                m_t[i]++;
            end
        end
    endtask

    task automatic step(input bit st_i, input bit sp_i, input bit ab_i, input bit rs_i);
        start = st_i; stop = sp_i; abort = ab_i; reset = rs_i;
        @(posedge clk);
        model_edge(st_i, sp_i, ab_i, rs_i);
        #1;
        chk("model_dut0", 32'(dut_vec(0)), 32'(exp_vec(0)));
        chk("model_dut1", 32'(dut_vec(1)), 32'(exp_vec(1)));
    endtask

    initial begin
        m_active = '{0, 0};
        m_t = '{0, 0};
        m_run_end = '{0, 0};
        start = 0; stop = 0; abort = 0; reset = 1;

        // Reset and no-op inputs in IDLE
        repeat (3) step(0, 0, 0, 1);
        chk("reset_state", 32'(st[0]), 32'd0);
        chk("reset_uplink", 32'(up[0]), 32'd1);
        chk("reset_token", 32'(tok[1]), 32'd0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("idle_noop_state", 32'(st[0]), 32'd0);
        chk("idle_noop_core", 32'(core[1]), 32'd1);

        // Nominal sequence
        step(1, 0, 0, 0);
        for (int e = 1; e <= 40; e++) begin
            step(0, 0, 0, 0);
            if (e == 3)  chk("nom_token_hi", 32'(tok[0]), 32'd1);
            if (e == 4)  chk("nom_token_lo", 32'(tok[0]), 32'd0);
            if (e == 8)  chk("nom_uplink", 32'(up[0]), 32'd0);
            if (e == 20) chk("nom_core", 32'(core[0]), 32'd0);
            if (e == 24) chk("nom_en_rise", 32'(en[0]), 32'd1);
            if (e == 34) chk("nom_en_fall", 32'(en[0]), 32'd0);
            if (e == 36) chk("nom_done_lo", 32'(done[0]), 32'd0);
            if (e == 37) chk("nom_done_hi", 32'(done[0]), 32'd1);
            if (e == 40) chk("run0_holds", 32'(en[1]), 32'd1);
        end
        step(0, 0, 1, 0);

        // Early stop, 7 cycles after en rises
        step(1, 0, 0, 0);
        for (int e = 1; e <= 36; e++) begin
            step(0, e == 31, 0, 0);
            if (e == 30) chk("stop_en_before", 32'(en[1]), 32'd1);
            if (e == 31) chk("stop_en_fall", 32'(en[1]), 32'd0);
            if (e == 33) chk("stop_done_lo", 32'(done[1]), 32'd0);
            if (e == 34) chk("stop_done_hi", 32'(done[1]), 32'd1);
        end
        step(0, 0, 1, 0);

        // Abort mid-DOWNSTREAM, then full replay
        step(1, 0, 0, 0);
        for (int e = 1; e <= 16; e++) step(0, 0, 0, 0);
        chk("pre_abort_state", 32'(st[0]), 32'd5);
        step(0, 0, 1, 0);
        chk("abort_state", 32'(st[0]), 32'd0);
        chk("abort_uplink", 32'(up[0]), 32'd1);
        chk("abort_core", 32'(core[0]), 32'd1);
        step(1, 0, 0, 0);
        for (int e = 1; e <= 37; e++) begin
            step(0, 0, 0, 0);
            if (e == 24) chk("replay_en", 32'(en[0]), 32'd1);
            if (e == 37) chk("replay_done", 32'(done[0]), 32'd1);
        end

        // Priority: abort over start, abort over RUN expiry
        step(1, 0, 1, 0);
        chk("abort_start_idle", 32'(st[0]), 32'd0);
        step(1, 0, 0, 0);
        for (int e = 1; e <= 33; e++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("abort_expiry_state", 32'(st[0]), 32'd0);
        for (int e = 0; e < 10; e++) step(0, 0, 0, 0);
        chk("abort_expiry_nodone", 32'(done[0]), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 599) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
